// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared data-memory geometry for the core, arbiter and Data_Memory
package mips_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 64;
  localparam int WAIT_W    = 4;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of consecutive denied external cycles
module starve_counter
  import mips_mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [WAIT_W-1:0] cnt,
  output logic              limit_hit
);

  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(LIMIT);

  assign limit_hit = (cnt == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !limit_hit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port share between the core (priority) and an external requester
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_we,
  input  logic [DATA_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_err,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [WAIT_W-1:0] wait_cnt;
  logic              limit_hit;
  logic              ext_grant;
  logic              ext_in_range;
  logic              ext_owns_port;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .clr       (ext_grant || !ext_valid),
    .inc       (ext_valid && cpu_req && !ext_grant),
    .cnt       (wait_cnt),
    .limit_hit (limit_hit)
  );

  assign ext_in_range  = ext_addr[DATA_W-1:2] < (DATA_W-2)'(MEM_WORDS);
  assign ext_grant     = ext_valid && (!cpu_req || limit_hit);
  assign ext_ready     = ext_grant;
  assign cpu_stall     = cpu_req && ext_grant;
  // An out-of-range grant still stalls the core but leaves the port on the core side with writes off.
  assign ext_owns_port = ext_grant && ext_in_range;

  assign cpu_rdata = mem_rdata;
  assign mem_addr  = ext_owns_port ? ext_addr  : cpu_addr;
  assign mem_wdata = ext_owns_port ? ext_wdata : cpu_wdata;

  always_comb begin
    mem_we = 1'b0;
    if (!reset) begin
      if (ext_owns_port) begin
        mem_we = ext_we;
      end else begin
        mem_we = cpu_req && cpu_we && !cpu_stall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_rvalid <= 1'b0;
      ext_err    <= 1'b0;
      ext_rdata  <= '0;
      stall_cnt  <= '0;
    end else begin
      ext_rvalid <= ext_grant && (!ext_in_range || !ext_we);
      ext_err    <= ext_grant && !ext_in_range;
      if (ext_owns_port && !ext_we) begin
        ext_rdata <= mem_rdata;
      end
      if (cpu_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural memory and model
module tb_dmem_arbiter;

  localparam int LIM = 4;
  localparam int CW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic        ext_ready, ext_rvalid, ext_err;
  logic [31:0] ext_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] stall_cnt;

  logic        mem_init = 1'b1;
  logic [31:0] ram [64];

  dmem_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_err(ext_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i);
  endfunction

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: age of the pending request, response registers, shadow memory
  int          m_wait, m_stall;
  logic        m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [64];
  logic        s_ready, s_stall, s_we;

  task automatic tick;
    bit in_rng, grant, stall, ext_path, we;
    logic [31:0] ea, ed;
    #3;
    in_rng   = (ext_addr >> 2) < 64;
    grant    = ext_valid && (!cpu_req || m_wait >= LIM);
    stall    = cpu_req && grant;
    ext_path = grant && in_rng;
    we       = !reset && (ext_path ? ext_we : (cpu_req && cpu_we && !stall));
    ea       = ext_path ? ext_addr : cpu_addr;
    ed       = ext_path ? ext_wdata : cpu_wdata;
    s_ready = ext_ready; s_stall = cpu_stall; s_we = mem_we;
    chk("ext_ready", ext_ready, grant);
    chk("cpu_stall", cpu_stall, stall);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, ea);
    if (we) chk("mem_wdata", mem_wdata, ed);
    chk("cpu_rdata", cpu_rdata, ref_mem[ea[7:2]]);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_stall = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
    end else begin
      m_rvalid = grant && (!in_rng || !ext_we);
      m_err    = grant && !in_rng;
      if (ext_path && !ext_we) m_rdata = ref_mem[ext_addr[7:2]];
      if (we) ref_mem[ea[7:2]] = ed;
      if (stall && m_stall < (1 << CW) - 1) m_stall++;
      if (grant || !ext_valid) m_wait = 0;
      else if (cpu_req && m_wait < LIM) m_wait++;
    end
    #1;
    chk("ext_rvalid", ext_rvalid, m_rvalid);
    chk("ext_err", ext_err, m_err);
    chk("ext_rdata", ext_rdata, m_rdata);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    ext_valid = v; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  task automatic idle;
    set_cpu(0, 0, 0, 0);
    set_ext(0, 0, 0, 0);
    tick();
  endtask

  typedef struct {
    logic        cpu_req, cpu_we, ext_valid, ext_we;
    logic [31:0] ext_addr;
    logic        exp_ready, exp_stall, exp_we;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev;
    bit held;
    int n;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_wait = 0; m_stall = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
    vecs[0] = '{0, 0, 1, 0, 32'h8,   1, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 32'h0,   0, 0, 1};
    vecs[2] = '{1, 0, 1, 0, 32'h8,   0, 0, 0};
    vecs[3] = '{0, 0, 1, 1, 32'h10,  1, 0, 1};
    vecs[4] = '{0, 0, 1, 1, 32'h100, 1, 0, 0};
    vecs[5] = '{1, 1, 1, 1, 32'h14,  0, 0, 1};

    @(posedge clk); #1;
    mem_init = 1'b0;
    tick();
    chk("reset_rvalid", ext_rvalid, 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_rdata", ext_rdata, 0);
    reset = 1'b0;

    // idle core, external read of word 2
    set_cpu(0, 0, 32'h40, 0);
    set_ext(1, 0, 32'h8, 0);
    tick();
    chk("idle_ready", s_ready, 1);
    chk("idle_stall", s_stall, 0);
    chk("idle_rvalid", ext_rvalid, 1);
    chk("idle_rdata", ext_rdata, 32'hDEADBEEF);
    chk("idle_err", ext_err, 0);

    for (int v = 0; v < 6; v++) begin
      idle();
      set_cpu(vecs[v].cpu_req, vecs[v].cpu_we, 32'h30, 32'h5500 + 32'(v));
      set_ext(vecs[v].ext_valid, vecs[v].ext_we, vecs[v].ext_addr, 32'h7700 + 32'(v));
      tick();
      chk("vec_ready", s_ready, vecs[v].exp_ready);
      chk("vec_stall", s_stall, vecs[v].exp_stall);
      chk("vec_we", s_we, vecs[v].exp_we);
    end

    // starvation: forced grant on the fifth contended cycle, then core owns the next four
    idle();
    set_cpu(1, 0, 32'h20, 0);
    set_ext(1, 0, 32'hC, 0);
    prev = 32'(stall_cnt);
    for (int c = 0; c < LIM; c++) begin
      tick();
      chk("starve_wait", s_ready, 0);
    end
    tick();
    chk("starve_grant", s_ready, 1);
    chk("starve_stall", s_stall, 1);
    chk("starve_cnt", 32'(stall_cnt), prev + 1);
    for (int c = 0; c < LIM; c++) begin
      tick();
      chk("starve_rewait", s_ready, 0);
    end
    tick();
    chk("starve_regrant", s_ready, 1);

    // stalled core store loses to forced external write, then re-issues
    idle();
    set_cpu(1, 1, 32'h4, 32'h11);
    set_ext(1, 1, 32'h4, 32'h22);
    for (int c = 0; c < LIM; c++) tick();
    tick();
    chk("supp_stall", s_stall, 1);
    chk("supp_word", ram[1], 32'h22);
    set_ext(0, 0, 0, 0);
    tick();
    chk("reissue_word", ram[1], 32'h11);

    // out-of-range external read
    idle();
    prev = ext_rdata;
    set_cpu(0, 0, 0, 0);
    set_ext(1, 0, 32'h100, 0);
    tick();
    chk("oor_ready", s_ready, 1);
    chk("oor_we", s_we, 0);
    chk("oor_rvalid", ext_rvalid, 1);
    chk("oor_err", ext_err, 1);
    chk("oor_rdata", ext_rdata, prev);

    // reset during a read grant suppresses the response
    set_ext(1, 0, 32'h8, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);

    // twenty forced stalls saturate a 4-bit counter
    idle();
    for (int k = 0; k < 20; k++) begin
      set_cpu(1, 0, 32'h8, 0);
      set_ext(1, 0, 32'h10, 0);
      n = 0;
      do begin
        tick();
        n++;
      end while (!s_ready && n < 10);
      if (!s_ready) chk("sat_grant_timeout", s_ready, 1);
    end
    chk("sat_cnt", 32'(stall_cnt), 15);

    // randomized traffic against the model
    reset = 1'b1;
    idle();
    reset = 1'b0;
    held = 0;
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1),
              32'($urandom_range(0, 63)) << 2, $urandom);
      if (!held) begin
        if ($urandom_range(0, 7) == 0)
          set_ext($urandom_range(0, 1), $urandom_range(0, 1),
                  32'($urandom_range(64, 127)) << 2, $urandom);
        else
          set_ext($urandom_range(0, 1), $urandom_range(0, 1),
                  32'($urandom_range(0, 63)) << 2, $urandom);
      end
      tick();
      held = ext_valid && !s_ready;
    end
    reset = 1'b0;
    idle();

    n = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) n++;
    chk("final_mem_diffs", 32'(n), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the single-cycle MIPS core and one external requester (debug/loader/DMA).
- Sits between the core's memory outputs and Data_Memory, in the top level.
- The core has fixed priority. A starvation counter guarantees the external requester a slot.
- The core is frozen via cpu_stall for any cycle in which it loses the port.

Parameters:
- DATA_W, 32, data/address width
- MEM_WORDS, 64, number of words in data memory; external addresses at or beyond this are errors
- STARVE_LIMIT, 4, consecutive denied cycles before the external requester is forcibly granted (legal range 1..15)
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- cpu_req, in, 1, core performs a memory access this cycle (load or store)
- cpu_we, in, 1, core store enable
- cpu_addr, in, DATA_W, core byte address
- cpu_wdata, in, DATA_W, core store data
- cpu_rdata, out, DATA_W, load data to core (combinational from mem_rdata)
- cpu_stall, out, 1, core must hold PC/registers this cycle
- ext_valid, in, 1, external request pending
- ext_ready, out, 1, external request accepted this cycle
- ext_we, in, 1, external write enable
- ext_addr, in, DATA_W, external byte address
- ext_wdata, in, DATA_W, external write data
- ext_rvalid, out, 1, read response / error valid (one-cycle pulse)
- ext_rdata, out, DATA_W, registered read data
- ext_err, out, 1, qualifies ext_rvalid: address out of range
- mem_we, out, 1, to data memory write enable
- mem_addr, out, DATA_W, to data memory address
- mem_wdata, out, DATA_W, to data memory write data
- mem_rdata, in, DATA_W, from data memory (combinational read)
- stall_cnt, out, CNT_W, saturating count of cycles with cpu_stall=1

Behaviour:
- Decision is combinational every cycle. State is wait_cnt (4 bits), ext_rvalid, ext_rdata, ext_err, and stall_cnt.
- ext_grant = ext_valid && (!cpu_req || wait_cnt == STARVE_LIMIT).
- ext_ready = ext_grant. cpu_stall = cpu_req && ext_grant.
- Handshake: once ext_valid rises, the requester holds it and ext_we/addr/wdata stable until ext_ready. Transfer occurs in the ext_ready cycle.
- Port mux when ext_grant and the address is in range: mem_addr=ext_addr, mem_wdata=ext_wdata, mem_we=ext_we.
- Port mux otherwise: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&&cpu_we.
- A stalled core store never reaches memory.
- Out-of-range rule: ext_addr[DATA_W-1:2] >= MEM_WORDS.
  - Such an access is accepted (ext_ready=1) but mem_we=0, so the core keeps the port that cycle.
  - cpu_stall is still asserted, so the slot is consumed deterministically.
- Read response: on an accepted in-range external read, at the next clock ext_rvalid=1, ext_rdata=mem_rdata (sampled in the grant cycle), ext_err=0.
- Error response: on an accepted out-of-range read or write, next cycle ext_rvalid=1, ext_err=1, ext_rdata unchanged.
- Accepted in-range writes produce no response.
- ext_rvalid and ext_err are single-cycle pulses. Back-to-back grants give back-to-back pulses.
- wait_cnt: cleared to 0 on ext_grant or when ext_valid=0. Otherwise it increments when ext_valid && cpu_req && !ext_grant, saturating at STARVE_LIMIT.
- Worst-case external latency is STARVE_LIMIT+1 cycles from ext_valid to ext_ready.
- After a forced grant, wait_cnt=0, so the core owns at least the next STARVE_LIMIT contended cycles.
- stall_cnt increments on each cpu_stall cycle and saturates at all-ones.
- cpu_rdata = mem_rdata always; the core ignores it when stalled.
- Reset values:
  - ext_rvalid=0, ext_err=0, ext_rdata=0, wait_cnt=0, stall_cnt=0.
  - Reset asserted in a grant cycle still blocks the response: ext_rvalid stays 0 after reset.
  - Combinational outputs track their inputs during reset, but mem_we is forced 0 while reset=1.
- Simultaneous ext_valid rising with cpu_req while wait_cnt=0: the core wins and wait_cnt becomes 1.

Decomposition:
- Shared package mips_mem_pkg holds DATA_W and MEM_WORDS (also used by Data_Memory and top).
- One natural sub-module: starve_counter (saturating wait_cnt with clear/inc/limit-hit).
- stall_cnt is inline.

Test Plan:
- Idle core: cpu_req=0, ext read addr 0x8 with mem word 2 = 0xDEADBEEF -> ext_ready same cycle, cpu_stall=0, next cycle ext_rvalid=1, ext_rdata=0xDEADBEEF, ext_err=0.
- Starvation: cpu_req held 1, ext_valid held from cycle 0 with STARVE_LIMIT=4 -> ext_ready=1 and cpu_stall=1 exactly in cycle 4, stall_cnt=1, then ext_ready=0 for the next 4 cycles if ext_valid is re-asserted.
- Store suppression: core store 0x11 to 0x4 colliding with forced ext write 0x22 to 0x4 -> memory word 1 = 0x22 after the cycle; core re-issues the next cycle -> word 1 = 0x11.
- Out of range: ext read addr 0x100 (word 64) -> ext_ready=1, mem_we=0, next cycle ext_rvalid=1, ext_err=1, ext_rdata unchanged.
- Reset mid-response: reset=1 in an ext read grant cycle -> ext_rvalid=0, stall_cnt=0, wait_cnt=0 the following cycle.
- Saturation: CNT_W=4, force 20 stall cycles -> stall_cnt stops at 15.
